// File: rtl/stb_pkg.sv
// Shared types and defaults for the store-buffer drain sequencer.
package stb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ADV  = 2'd2
    } stb_drain_state_e;

    localparam int STB_STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/stb_sat_counter.sv
// Saturating up-counter with synchronous clear; tracks how long a ready store
// has been deferred in favour of loads.
module stb_sat_counter
    import stb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LIMIT = STB_STARVE_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/stb_drain_controller.sv
// Read-side sequencer for the store buffer: drains committed stores to the
// dcache, arbitrates against loads with a starvation guard, services fences.
module stb_drain_controller
    import stb_pkg::*;
#(
    parameter int STARVE_LIMIT = STB_STARVE_LIMIT_DEF,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb_empty,
    input  logic stb_full,
    input  logic lsu2dcache_req,
    input  logic dcache2stb_ack,
    input  logic fence_req,
    output logic stb_rd_en,
    output logic rd_sel,
    output logic stb2dcache_req,
    output logic stb_dcache_owner,
    output logic fence_done
);

    stb_drain_state_e state_q;
    stb_drain_state_e state_d;
    logic             fence_active_q;
    logic             fence_active_d;
    logic             req_q;
    logic             req_d;

    logic             issue;
    logic             starve_inc;
    logic             at_limit;
    logic             ack_hit;
    logic             fence_done_c;
    logic [CNT_W-1:0] starve_cnt;

    stb_sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (starve_inc),
        .clr      (issue),
        .cnt      (starve_cnt),
        .at_limit (at_limit)
    );

    always_comb begin
        issue        = (state_q == IDLE) && !stb_empty &&
                       (stb_full || fence_active_q || at_limit || !lsu2dcache_req);
        starve_inc   = (state_q == IDLE) && !stb_empty && lsu2dcache_req && !issue;
        ack_hit      = (state_q == REQ) && dcache2stb_ack;
        fence_done_c = fence_active_q && stb_empty && (state_q == IDLE);

        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = REQ;
            REQ:     if (dcache2stb_ack) state_d = ADV;
            ADV:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_d = (state_d == REQ);

        // Completion wins over a coincident new fence: the drained buffer satisfies it.
        fence_active_d = fence_active_q;
        if (fence_done_c) begin
            fence_active_d = 1'b0;
        end else if (fence_req) begin
            fence_active_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            fence_active_q <= 1'b0;
            req_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            fence_active_q <= fence_active_d;
            req_q          <= req_d;
        end
    end

    assign rd_sel           = req_q;
    assign stb2dcache_req   = req_q;
    assign stb_dcache_owner = req_q;
    assign stb_rd_en        = ack_hit;
    assign fence_done       = fence_done_c;

endmodule
